shot_charger: RTL and testbench
===============================

SHOT_CHARGER -- requirements
Module: shot_charger

Interface
REQ-001 Parameter MAX_POWER, default 255, is the highest shot power value (8-bit).
REQ-002 Parameter TICK_CYCLES, default 390625, is the number of clock cycles per power step of ±1.
REQ-003 Parameter DEBOUNCE_CYCLES, default 65536, is the number of cycles the synchronized button must stay stable before a level change is accepted.
REQ-004 clk_in  input  1  system clock; only clock in the block.
REQ-005 rst_in_n  input  1  reset; asynchronous, active-low.
REQ-006 swing_btn  input  1  raw, asynchronous, bouncing shot button; 1 = pressed.
REQ-007 game_state  input  3  gameplay state code; 0 = RESTING.
REQ-008 user_input  output  8  shot power; valid while user_rdy = 1 and held afterwards.
REQ-009 user_rdy  output  1  single-cycle shot strobe.
REQ-010 power_level  output  8  live meter value for the HUD.
REQ-011 charging  output  1  1 while in the CHARGING state.

Function
REQ-012 swing_btn SHALL pass through a 2-flop synchronizer, then a debouncer; the result is btn_db.
REQ-013 The FSM SHALL have exactly these states: IDLE, ARMED, CHARGING, FIRE, WAIT_MOVE.
REQ-014 IDLE: when game_state == 0 and btn_db == 0, go to ARMED; this forbids a shot from a button already held.
REQ-015 ARMED: a btn_db rising edge with game_state == 0 goes to CHARGING, clears power_level and clears the tick counter.
REQ-016 CHARGING: the tick counter counts 0..TICK_CYCLES-1; at the wrap, power_level steps by one in the current direction.
REQ-017 Power stepping SHALL be bounded to [0, MAX_POWER] and SHALL never overflow or underflow 8 bits.
REQ-018 CHARGING, btn_db falling with power_level > 0: go to FIRE.
REQ-019 CHARGING, btn_db falling with power_level == 0: no shot; return to ARMED.
REQ-020 FIRE, one cycle only:
- user_input <= power_level and user_rdy = 1 on this cycle;
- then go to WAIT_MOVE.
- Release to user_rdy latency is exactly 1 cycle after btn_db falls.
REQ-021 WAIT_MOVE: wait for game_state != 0, then go to IDLE; the block SHALL issue no further user_rdy until the next full arm cycle.
REQ-022 If game_state != 0 while in ARMED or CHARGING (e.g. new_game), go to IDLE, zero power_level and emit no strobe; this takes priority over a simultaneous release.
REQ-023 user_rdy SHALL be 0 in every state other than FIRE.
REQ-024 user_input SHALL hold its last fired value until the next FIRE.

Reset
REQ-025 Asserting rst_in_n low SHALL immediately force the following, asynchronously:
- state IDLE;
- user_input = 0, user_rdy = 0, power_level = 0, charging = 0;
- synchronizer, debouncer and counters cleared.
REQ-026 Reset during CHARGING or FIRE SHALL suppress any pending strobe.
REQ-027 After release, the block SHALL see btn_db == 0 before arming.

Configuration
REQ-028 Macro SHOT_PINGPONG_EN defined: the meter counts up to MAX_POWER, reverses, counts down to 0, reverses, and repeats while the button is held; direction resets to up on each CHARGING entry.
REQ-029 SHOT_PINGPONG_EN undefined: the meter saturates at MAX_POWER and holds there.

Structure
REQ-030 The shared package gameplay_pkg SHALL hold:
- the gameplay_state enum (RESTING=0, CHARGING_HIT=1, ON_HIT=2, BALL_MOVING=3, ON_WALL_COLLISION=4, IN_HOLE=5);
- the shot_charger FSM state typedef.
REQ-031 Synchronizer plus stability counter SHALL be one sub-module, debouncer, parameterized by DEBOUNCE_CYCLES.

Verification
REQ-032 Bench parameters: TICK_CYCLES=4, DEBOUNCE_CYCLES=2, MAX_POWER=255.
REQ-033 Basic shot: game_state=0, press, hold 40 cycles after btn_db rises, release → exactly one user_rdy pulse with user_input=10, then no pulse while game_state=3.
REQ-034 Ping-pong (SHOT_PINGPONG_EN defined): hold 1100 cycles → power_level peaks at 255, then descends, reading 255-(275-255)=235 at release; user_input=235.
REQ-035 Saturate (SHOT_PINGPONG_EN undefined): same stimulus as REQ-034 → user_input=255.
REQ-036 Zero-power release: release after 2 cycles of charging → no user_rdy, state ARMED, charging=0.
REQ-037 Abort: game_state goes 0→3 mid-charge → no strobe; a button still held when game_state returns to 0 → no arm until released.
REQ-038 Async reset: rst_in_n pulsed low for less than one clock mid-FIRE → user_rdy=0 and all outputs 0 immediately.

Source files
------------

// File: rtl/gameplay_pkg.sv
// rtl/gameplay_pkg.sv - shared gameplay state codes and shot_charger FSM states
package gameplay_pkg;

  typedef enum logic [2:0] {
    RESTING           = 3'd0,
    CHARGING_HIT      = 3'd1,
    ON_HIT            = 3'd2,
    BALL_MOVING       = 3'd3,
    ON_WALL_COLLISION = 3'd4,
    IN_HOLE           = 3'd5
  } gameplay_state_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    CHARGING  = 3'd2,
    FIRE      = 3'd3,
    WAIT_MOVE = 3'd4
  } charger_state_e;

endpackage

// File: rtl/debouncer.sv
// rtl/debouncer.sv - 2-flop synchronizer plus stability counter for a raw button
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clk_in,
  input  logic rst_in_n,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized level disagrees with the
  // accepted one; any bounce back to the accepted level restarts it.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_db = db_q;

endmodule

// File: rtl/shot_charger.sv
// rtl/shot_charger.sv - hold-to-charge shot power meter; SHOT_PINGPONG_EN selects a bouncing meter
module shot_charger
  import gameplay_pkg::*;
#(
  parameter int unsigned MAX_POWER       = 255,
  parameter int unsigned TICK_CYCLES     = 390625,
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       swing_btn,
  input  logic [2:0] game_state,
  output logic [7:0] user_input,
  output logic       user_rdy,
  output logic [7:0] power_level,
  output logic       charging
);

  localparam int unsigned TW = $clog2(TICK_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [7:0] MAX_P = 8'(MAX_POWER);

  charger_state_e state_q, state_d;
  logic [TW-1:0]  tick_q, tick_d, tick_next;
  logic [7:0]     power_q, power_d, power_next;
  logic [7:0]     user_input_q, user_input_d;
  logic           user_rdy_q, user_rdy_d;
  logic           charging_q, charging_d;
  logic           btn_db, resting, tick_wrap;
`ifdef SHOT_PINGPONG_EN
  logic           dir_up_q, dir_up_d, dir_next;
`endif

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clk_in  (clk_in),
    .rst_in_n(rst_in_n),
    .btn_raw (swing_btn),
    .btn_db  (btn_db)
  );

  assign resting   = (game_state == 3'(RESTING));
  assign tick_wrap = (tick_q == TICK_LAST);
  assign tick_next = tick_wrap ? '0 : tick_q + TW'(1);

  // Meter value after this cycle's tick; every CHARGING cycle counts, release cycle included.
  always_comb begin
    power_next = power_q;
`ifdef SHOT_PINGPONG_EN
    dir_next = dir_up_q;
    if (tick_wrap) begin
      if (dir_up_q) begin
        if (power_q >= MAX_P) begin
          dir_next   = 1'b0;
          power_next = (power_q == 8'd0) ? 8'd0 : power_q - 8'd1;
        end else begin
          power_next = power_q + 8'd1;
        end
      end else if (power_q == 8'd0) begin
        dir_next   = 1'b1;
        power_next = (MAX_P == 8'd0) ? 8'd0 : 8'd1;
      end else begin
        power_next = power_q - 8'd1;
      end
    end
`else
    if (tick_wrap && power_q < MAX_P) begin
      power_next = power_q + 8'd1;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    power_d      = power_q;
    user_input_d = user_input_q;
`ifdef SHOT_PINGPONG_EN
    dir_up_d     = dir_up_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (resting && !btn_db) state_d = ARMED;
      end
      ARMED: begin
        if (!resting) begin
          state_d = IDLE;
          power_d = 8'd0;
        end else if (btn_db) begin
          state_d = CHARGING;
          power_d = 8'd0;
          tick_d  = '0;
`ifdef SHOT_PINGPONG_EN
          dir_up_d = 1'b1;
`endif
        end
      end
      CHARGING: begin
        // A game-state change wins over a release in the same cycle.
        if (!resting) begin
          state_d = IDLE;
          power_d = 8'd0;
        end else begin
          tick_d  = tick_next;
          power_d = power_next;
`ifdef SHOT_PINGPONG_EN
          dir_up_d = dir_next;
`endif
          if (!btn_db) begin
            if (power_next != 8'd0) begin
              state_d      = FIRE;
              user_input_d = power_next;
            end else begin
              state_d = ARMED;
            end
          end
        end
      end
      FIRE:      state_d = WAIT_MOVE;
      WAIT_MOVE: if (!resting) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    user_rdy_d = (state_d == FIRE);
    charging_d = (state_d == CHARGING);
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      power_q      <= 8'd0;
      user_input_q <= 8'd0;
      user_rdy_q   <= 1'b0;
      charging_q   <= 1'b0;
`ifdef SHOT_PINGPONG_EN
      dir_up_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      power_q      <= power_d;
      user_input_q <= user_input_d;
      user_rdy_q   <= user_rdy_d;
      charging_q   <= charging_d;
`ifdef SHOT_PINGPONG_EN
      dir_up_q     <= dir_up_d;
`endif
    end
  end

  assign user_input  = user_input_q;
  assign user_rdy    = user_rdy_q;
  assign power_level = power_q;
  assign charging    = charging_q;

endmodule

// File: tb/tb_shot_charger.sv
// tb/tb_shot_charger.sv - directed self-checking bench for shot_charger
module tb_shot_charger;

  logic       clk_in = 1'b0;
  logic       rst_in_n = 1'b0;
  logic       swing_btn = 1'b0;
  logic [2:0] game_state = 3'd0;
  logic [7:0] user_input;
  logic       user_rdy;
  logic [7:0] power_level;
  logic       charging;

  int checks = 0;
  int errors = 0;
  int rdy_cnt = 0;
  int last_ui = -1;
  int base;
  bit found;

`ifdef SHOT_PINGPONG_EN
  localparam int EXP_LONG = 235;
`else
  localparam int EXP_LONG = 255;
`endif

  shot_charger #(.MAX_POWER(255), .TICK_CYCLES(4), .DEBOUNCE_CYCLES(2)) dut (
    .clk_in     (clk_in),
    .rst_in_n   (rst_in_n),
    .swing_btn  (swing_btn),
    .game_state (game_state),
    .user_input (user_input),
    .user_rdy   (user_rdy),
    .power_level(power_level),
    .charging   (charging)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (user_rdy) begin
      rdy_cnt = rdy_cnt + 1;
      last_ui = int'(user_input);
    end
  end

  task automatic check(input string tag, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic press(input int n);
    swing_btn = 1'b1;
    cycles(n);
    swing_btn = 1'b0;
  endtask

  initial begin
    cycles(1);
    #1;
    check("rst_user_input", int'(user_input), 0);
    check("rst_user_rdy", int'(user_rdy), 0);
    check("rst_power", int'(power_level), 0);
    check("rst_charging", int'(charging), 0);
    rst_in_n = 1'b1;
    cycles(5);

    // basic shot: 40 cycles held -> 10 steps of 4 cycles
    base = rdy_cnt;
    swing_btn = 1'b1;
    cycles(20);
    check("basic_charging", int'(charging), 1);
    cycles(20);
    swing_btn = 1'b0;
    cycles(12);
    check("basic_pulses", rdy_cnt - base, 1);
    check("basic_value", last_ui, 10);
    check("basic_hold", int'(user_input), 10);
    game_state = 3'd3;
    press(20);
    cycles(10);
    check("wait_move_no_pulse", rdy_cnt - base, 1);
    check("wait_move_no_charge", int'(charging), 0);
    game_state = 3'd0;
    cycles(6);

    // zero-power release returns to ARMED; a later press still fires
    base = rdy_cnt;
    press(2);
    cycles(10);
    check("zero_no_pulse", rdy_cnt - base, 0);
    check("zero_charging", int'(charging), 0);
    press(8);
    cycles(12);
    check("rearm_pulses", rdy_cnt - base, 1);
    check("rearm_value", last_ui, 2);
    check("held_value", int'(user_input), 2);
    game_state = 3'd3;
    cycles(3);
    game_state = 3'd0;
    cycles(6);

    // abort mid-charge, then button still held when play resumes
    base = rdy_cnt;
    swing_btn = 1'b1;
    cycles(30);
    game_state = 3'd3;
    cycles(3);
    check("abort_charging", int'(charging), 0);
    check("abort_power", int'(power_level), 0);
    cycles(5);
    game_state = 3'd0;
    cycles(12);
    check("held_no_arm", int'(charging), 0);
    swing_btn = 1'b0;
    cycles(12);
    check("abort_no_pulse", rdy_cnt - base, 0);
    press(12);
    cycles(12);
    check("after_abort_value", last_ui, 3);
    check("after_abort_pulses", rdy_cnt - base, 1);
    game_state = 3'd3;
    cycles(3);
    game_state = 3'd0;
    cycles(6);

    // long hold: ping-pong or saturate
    base = rdy_cnt;
    press(1100);
    cycles(12);
    check("long_value", last_ui, EXP_LONG);
    check("long_meter", int'(power_level), EXP_LONG);
    check("long_pulses", rdy_cnt - base, 1);
    game_state = 3'd3;
    cycles(3);
    game_state = 3'd0;
    cycles(6);

    // async reset shorter than a clock while FIRE
    press(20);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk_in);
      if (user_rdy) found = 1'b1;
    end
    check("fire_seen", int'(found), 1);
    #1 rst_in_n = 1'b0;
    #1;
    check("areset_rdy", int'(user_rdy), 0);
    check("areset_input", int'(user_input), 0);
    check("areset_power", int'(power_level), 0);
    check("areset_charging", int'(charging), 0);
    #2 rst_in_n = 1'b1;
    cycles(8);
    base = rdy_cnt;
    press(8);
    cycles(12);
    check("post_reset_value", last_ui, 2);
    check("post_reset_pulses", rdy_cnt - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
